// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   chunk_w  : bits resolved per pipeline stage (WIDTH/STAGES)
//   cfg_ok   : legality of a WIDTH/STAGES pairing, checked at elaboration
//   stage_rec_t : stage register layout for the default 16-bit/4-stage build;
//                 the top builds the same record per stage with stage-sized
//                 fields so no dead bits are registered.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(int width, int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

  localparam int DEF_CHUNK = chunk_w(DEF_WIDTH, DEF_STAGES);

  typedef struct packed {
    logic                 vld;
    logic                 carry;
    logic [DEF_WIDTH-1:0] psum;
    logic [DEF_WIDTH-1:0] a_rem;
    logic [DEF_WIDTH-1:0] b_rem;
  } stage_rec_t;

endpackage

// File: rtl/adder_chunk.sv
// W-bit ripple-carry adder built from full_adder cells.
//   a, b, ci : operands and carry in
//   s        : W-bit sum
//   co       : carry out of the top bit
//   c_msb    : carry into the top bit (for signed overflow)
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Stage k resolves bits
// [k*CHUNK +: CHUNK]; pending upper operand bits ride forward with the beat
// and finished low sum bits are carried along for alignment. Latency STAGES.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sub=1               : a - b - cin; cout=1 means no borrow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  // Whole pipe advances together; bubbles are kept, never squeezed out.
  logic              en;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst)
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k*CHUNK;  // operand bits still pending here
    localparam int LO = k*CHUNK;          // sum bits already resolved

    logic [IW-1:0]       a_in, b_in;
    logic                c_in;
    logic [CHUNK-1:0]    s;
    logic                co, c_msb;
    logic [LO+CHUNK-1:0] psum_in;

    if (k == 0) begin : g_src
      // Subtract folds into the operands here so sub never enters the pipe.
      assign a_in    = a;
      assign b_in    = sub ? ~b : b;
      assign c_in    = sub ? ~cin : cin;
      assign psum_in = s;
    end else begin : g_src
      assign a_in    = g_st[k-1].g_mid.q.a_rem;
      assign b_in    = g_st[k-1].g_mid.q.b_rem;
      assign c_in    = g_st[k-1].g_mid.q.carry;
      assign psum_in = {s, g_st[k-1].g_mid.q.psum};
    end

    if (k < STAGES-1) begin : g_mid
      typedef struct packed {
        logic                carry;
        logic [LO+CHUNK-1:0] psum;
        logic [IW-CHUNK-1:0] a_rem;
        logic [IW-CHUNK-1:0] b_rem;
      } rec_t;
      rec_t q;

      // Carry into the chunk MSB only matters at the top of the word.
      adder_chunk #(.W(CHUNK)) u_chunk (
        .a     (a_in[CHUNK-1:0]),
        .b     (b_in[CHUNK-1:0]),
        .ci    (c_in),
        .s     (s),
        .co    (co),
        .c_msb ()
      );
      assign c_msb = 1'b0;

      always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (en && vld_pipe[k]) begin
          q.carry <= co;
          q.psum  <= psum_in;
          q.a_rem <= a_in[IW-1:CHUNK];
          q.b_rem <= b_in[IW-1:CHUNK];
        end
    end else begin : g_last
      adder_chunk #(.W(CHUNK)) u_chunk (
        .a     (a_in[CHUNK-1:0]),
        .b     (b_in[CHUNK-1:0]),
        .ci    (c_in),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
      );

      // Output regs load only on valid beats so they hold across bubbles.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
        end else if (en && vld_pipe[k]) begin
          sum  <= psum_in;
          cout <= co;
          ovf  <= co ^ c_msb;
        end
    end
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor built from chained full-adder cells.
- The operand word is split into STAGES equal chunks, and one chunk's carry chain is resolved per pipeline stage.
- Provides a valid/ready handshake on input and output, plus carry-out and signed overflow flags.
- Serves as the accumulation and partial-product adder for wide multiplier datapaths in the design.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥1 and divisible by STAGES.
- STAGES, 4, number of pipeline stages, which equals the latency in cycles; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out for add; inverted borrow for subtract (1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock, asynchronous active-high reset named rst.
  - On assertion, all stage valid bits, sum, cout and ovf clear to 0 immediately.
  - in_ready is 1 while no stall is present.
  - Reset mid-operation discards all in-flight beats with no output.
- Operation mapping:
  - Add: result = a + b + cin.
  - Subtract: b_eff = ~b and c_eff = ~cin, i.e. result = a − b − cin.
  - Operands are inverted at capture, so sub is not carried down the pipe.
- Pipeline, with CHUNK = WIDTH/STAGES:
  - Stage k (0-based) adds bits [k*CHUNK +: CHUNK] of a and b_eff using the carry from stage k−1 (c_eff for stage 0).
  - Upper operand chunks are skewed forward; completed lower sum chunks are delayed for alignment.
  - Registers per beat are carry, completed sum bits, remaining operand bits and a valid bit.
- Flags:
  - cout = carry out of the MSB.
  - ovf = carry into the MSB XOR carry out of the MSB, computed in the final stage.
- Latency: a beat accepted in cycle t presents out_valid=1 in cycle t+STAGES when unstalled.
- Handshake:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en.
  - A beat is accepted when in_valid && in_ready.
  - When en=0, every stage holds and sum/cout/ovf stay stable while out_valid=1.
  - Bubbles are not collapsed.
  - Full throughput is one beat per cycle while out_ready stays 1.
- Boundary conditions:
  - STAGES=1: purely registered adder, latency 1.
  - STAGES=WIDTH: one bit per stage.
  - in_valid while in_ready=0: the beat is not taken, and upstream must hold it.
  - Output handed off and input accepted in the same cycle: both occur, with no loss and no duplication.
  - Order is strictly FIFO.
  - Outputs never carry X after reset.

Decomposition:
- A shared package holds:
  - constant CHUNK = WIDTH/STAGES;
  - a stage-register record type: valid, carry, partial sum, remaining a, remaining b;
  - an elaboration-time check that WIDTH % STAGES == 0.
- One sub-module is natural: adder_chunk, a CHUNK-bit ripple adder of full_adder instances exposing carry into the MSB for the overflow computation.
- pipelined_adder generates STAGES instances of adder_chunk, plus the skew/delay registers and handshake.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- Reset: assert rst asynchronously mid-cycle → out_valid=0, sum=0x0000, cout=0, ovf=0 immediately; after release, in_ready=1.
- Add: a=0xFFFF, b=0x0001, cin=0, sub=0 → 4 cycles later sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x8000, b=0x0001, cin=0, sub=1 → sum=0x7FFF, cout=1, ovf=1. Also a=0x0000, b=0x0001, cin=1 → sum=0xFFFE, cout=0, ovf=0.
- Backpressure: stream 8 random beats with out_ready=0 from the cycle the first result appears → in_ready=0 at that point, outputs stable; releasing out_ready drains all 8 in order, matching the reference model.
- Reset mid-flight: accept 3 beats, assert rst 2 cycles later → no result is ever presented; the first post-reset beat emerges after exactly 4 cycles.
- Config sweep: STAGES=1 and STAGES=16 with 1000 random beats and random out_ready → every result equals the model and latency equals STAGES when unstalled.
